rv32_hazard_scoreboard: RTL

Parametrised hazard and pipeline-control unit for the rv32 core, generalising the fixed five-stage hazard logic to TRACK_DEPTH post-decode stages. It keeps a registered shadow of every in-flight instruction's destination, load and fence status. From that shadow it produces per-stage stall/flush controls, multi-cycle load-use interlocks and fence draining. It sits beside the pipeline, fed by fetch/decode control and per-stage wait requests.

---
 rtl/rv32_hazard_scoreboard.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/rv32_hazard_scoreboard.sv
// Hazard/pipeline-control unit tracking TRACK_DEPTH post-decode stages for the rv32 core.
// Optional macro RV32_HAZARD_PERF_EN adds saturating load-use, bus-stall and branch-flush counters.
module rv32_hazard_scoreboard #(
  parameter int unsigned TRACK_DEPTH       = 3,
  parameter int unsigned BRANCH_STAGE      = 1,
  parameter int unsigned LOAD_USE_DISTANCE = 1
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [4:0]             fetch_rs1_unreg_in,
  input  logic [4:0]             fetch_rs2_unreg_in,
  input  logic                   fetch_fence_unreg_in,
  input  logic                   decode_valid_in,
  input  logic [4:0]             decode_rd_in,
  input  logic                   decode_rd_write_in,
  input  logic                   decode_mem_read_in,
  input  logic                   decode_mem_fence_in,
  input  logic                   instr_read_in,
  input  logic                   instr_ready_in,
  input  logic [TRACK_DEPTH-1:0] stage_wait_in,
  input  logic                   branch_taken_in,
  output logic                   fetch_stall_out,
  output logic                   fetch_flush_out,
  output logic                   decode_stall_out,
  output logic                   decode_flush_out,
  output logic [TRACK_DEPTH-1:0] stage_stall_out,
  output logic [TRACK_DEPTH-1:0] stage_flush_out
`ifdef RV32_HAZARD_PERF_EN
  ,
  output logic [31:0]            perf_load_use_cycles_out,
  output logic [31:0]            perf_bus_stall_cycles_out,
  output logic [31:0]            perf_branch_flush_out
`endif
);

  localparam int unsigned LuShadow = LOAD_USE_DISTANCE - 1;

  logic [TRACK_DEPTH-1:0]      valid_q, valid_d;
  logic [TRACK_DEPTH-1:0]      load_q, load_d;
  logic [TRACK_DEPTH-1:0]      fence_q, fence_d;
  logic [TRACK_DEPTH-1:0][4:0] rd_q, rd_d;

  logic [TRACK_DEPTH-1:0] stall;
  logic [TRACK_DEPTH-1:0] flush;
  logic                   br;
  logic                   load_use;
  logic                   fence_hazard;
  logic                   bus_wait;

  function automatic logic src_match(logic [4:0] rd, logic [4:0] rs1, logic [4:0] rs2);
    return (rd != 5'd0) && ((rd == rs1) || (rd == rs2));
  endfunction

  // A wait in any later stage backs up every earlier stage.
  always_comb begin
    stall = '0;
    for (int unsigned k = 0; k < TRACK_DEPTH; k++) begin
      stall[k] = |(stage_wait_in >> k);
    end
  end

  assign br       = branch_taken_in && !stall[BRANCH_STAGE];
  assign bus_wait = instr_read_in && !instr_ready_in;

  always_comb begin
    load_use = decode_valid_in && decode_mem_read_in && decode_rd_write_in &&
               src_match(decode_rd_in, fetch_rs1_unreg_in, fetch_rs2_unreg_in);
    for (int unsigned k = 0; k < TRACK_DEPTH; k++) begin
      if ((k < LuShadow) && valid_q[k] && load_q[k] &&
          src_match(rd_q[k], fetch_rs1_unreg_in, fetch_rs2_unreg_in)) begin
        load_use = 1'b1;
      end
    end
    fence_hazard = fetch_fence_unreg_in || (decode_valid_in && decode_mem_fence_in) ||
                   (|(valid_q & fence_q));
  end

  // Decode and stage 0 share one stall, so stage 0 only bubbles on a branch.
  always_comb begin
    flush    = '0;
    flush[0] = br && (BRANCH_STAGE > 0);
    for (int unsigned k = 1; k < TRACK_DEPTH; k++) begin
      flush[k] = (stall[k-1] && !stall[k]) || (br && (k < BRANCH_STAGE));
    end
  end

  assign stage_stall_out  = stall;
  assign stage_flush_out  = flush;
  assign decode_stall_out = stall[0];
  assign fetch_stall_out  = stall[0] || load_use || fence_hazard || bus_wait;
  assign fetch_flush_out  = 1'b0;
  assign decode_flush_out = fetch_stall_out || br;

  // The decode instruction itself still advances on a fetch-stall flush (the bubble lands
  // behind it); only a taken branch kills it.
  always_comb begin
    valid_d = valid_q;
    rd_d    = rd_q;
    load_d  = load_q;
    fence_d = fence_q;
    if (flush[0]) begin
      valid_d[0] = 1'b0;
    end else if (!stall[0]) begin
      valid_d[0] = decode_valid_in && !br;
      rd_d[0]    = decode_rd_in;
      load_d[0]  = decode_mem_read_in && decode_rd_write_in;
      fence_d[0] = decode_mem_fence_in;
    end
    for (int unsigned k = 1; k < TRACK_DEPTH; k++) begin
      if (flush[k]) begin
        valid_d[k] = 1'b0;
      end else if (!stall[k]) begin
        valid_d[k] = valid_q[k-1];
        rd_d[k]    = rd_q[k-1];
        load_d[k]  = load_q[k-1];
        fence_d[k] = fence_q[k-1];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= '0;
      rd_q    <= '0;
      load_q  <= '0;
      fence_q <= '0;
    end else begin
      valid_q <= valid_d;
      rd_q    <= rd_d;
      load_q  <= load_d;
      fence_q <= fence_d;
    end
  end

`ifdef RV32_HAZARD_PERF_EN
  logic [31:0] perf_lu_q, perf_lu_d;
  logic [31:0] perf_bus_q, perf_bus_d;
  logic [31:0] perf_br_q, perf_br_d;

  always_comb begin
    perf_lu_d  = perf_lu_q;
    perf_bus_d = perf_bus_q;
    perf_br_d  = perf_br_q;
    if (load_use && (perf_lu_q != '1)) perf_lu_d = perf_lu_q + 32'd1;
    if (((|stage_wait_in) || bus_wait) && (perf_bus_q != '1)) perf_bus_d = perf_bus_q + 32'd1;
    if (br && (perf_br_q != '1)) perf_br_d = perf_br_q + 32'd1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      perf_lu_q  <= '0;
      perf_bus_q <= '0;
      perf_br_q  <= '0;
    end else begin
      perf_lu_q  <= perf_lu_d;
      perf_bus_q <= perf_bus_d;
      perf_br_q  <= perf_br_d;
    end
  end

  assign perf_load_use_cycles_out  = perf_lu_q;
  assign perf_bus_stall_cycles_out = perf_bus_q;
  assign perf_branch_flush_out     = perf_br_q;
`endif

endmodule
